// File: rtl/disp_scan_driver.sv
// Multiplexed 7-segment scan driver.
// Time-multiplexes NUM_DIGITS digits, one slot of REFRESH_DIV cycles each.
// The first cycle of every slot is an anti-ghost gap in which no anode is driven.
// A per-frame snapshot of the digit, dp and blink inputs prevents tearing mid-frame.
// Leading-zero blanking, blinking and optional pin inversion are applied at the output.
module disp_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic          INV        = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt_r;
  logic [IW-1:0]           idx_r;
  logic [BW-1:0]           bcnt_r;
  logic                    phase_r;
  logic                    first_r;
  logic [4*NUM_DIGITS-1:0] snap_dig_r;
  logic [NUM_DIGITS-1:0]   snap_dp_r;
  logic [NUM_DIGITS-1:0]   snap_blink_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    tick_r;

  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic                    lz_blank_s;
  logic                    upper_zero_s;
  logic                    dp_sel_s;
  logic                    blink_sel_s;
  logic [6:0]              seg_s;
  logic                    dp_s;
  logic [NUM_DIGITS-1:0]   an_s;

  // Segment pattern (A..G on bits 6..0) for a 4-bit code; codes 10-15 blank unless hex_en.
  function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_en);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110010;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      4'd10:   pat = hex_en ? 7'b1110111 : 7'b0000000;
      4'd11:   pat = hex_en ? 7'b0011111 : 7'b0000000;
      4'd12:   pat = hex_en ? 7'b1001110 : 7'b0000000;
      4'd13:   pat = hex_en ? 7'b0111101 : 7'b0000000;
      4'd14:   pat = hex_en ? 7'b1001111 : 7'b0000000;
      4'd15:   pat = hex_en ? 7'b1000111 : 7'b0000000;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  // Last cycle of the last slot: the frame boundary.
  assign wrap_s = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);

  // Refresh counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Blink phase toggles once every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_r  <= {BW{1'b0}};
      phase_r <= 1'b0;
    end else if (wrap_s) begin
      if (bcnt_r == BLINK_LAST) begin
        bcnt_r  <= {BW{1'b0}};
        phase_r <= ~phase_r;
      end else begin
        bcnt_r <= bcnt_r + {{(BW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Frame snapshot: loads at the frame boundary and right after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r      <= 1'b1;
      snap_dig_r   <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_r    <= {NUM_DIGITS{1'b0}};
      snap_blink_r <= {NUM_DIGITS{1'b0}};
    end else begin
      first_r <= 1'b0;
      if (wrap_s || first_r) begin
        snap_dig_r   <= digits_in;
        snap_dp_r    <= dp_in;
        snap_blink_r <= blink_mask;
      end
    end
  end

  // Select the active digit and work out blanking for it.
  always_comb begin
    nib_s        = 4'd0;
    dp_sel_s     = 1'b0;
    blink_sel_s  = 1'b0;
    lz_blank_s   = 1'b0;
    upper_zero_s = 1'b1;
    an_s         = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        nib_s       = snap_dig_r[4*i +: 4];
        dp_sel_s    = snap_dp_r[i];
        blink_sel_s = snap_blink_r[i];
        an_s[i]     = (cnt_r != {CW{1'b0}});
      end else begin
        an_s[i] = 1'b0;
      end
    end
    // Walk from the most significant digit down; digit 0 is never a candidate.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero_s = upper_zero_s & (snap_dig_r[4*i +: 4] == 4'd0);
      if (idx_r == IW'(i)) begin
        lz_blank_s = blank_lz & upper_zero_s;
      end else begin
        lz_blank_s = lz_blank_s;
      end
    end
    if (phase_r && blink_sel_s) begin
      seg_s = 7'b0000000;
      dp_s  = 1'b0;
    end else if (lz_blank_s) begin
      seg_s = 7'b0000000;
      dp_s  = dp_sel_s;
    end else begin
      seg_s = seg_decode(nib_s, hex_mode);
      dp_s  = dp_sel_s;
    end
  end

  // Registered pin drivers with optional inversion; frame_tick marks index reaching 0 after a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r  <= {7{INV}};
      dp_r   <= INV;
      an_r   <= {NUM_DIGITS{INV}};
      tick_r <= 1'b0;
    end else begin
      seg_r  <= seg_s ^ {7{INV}};
      dp_r   <= dp_s ^ INV;
      an_r   <= an_s ^ {NUM_DIGITS{INV}};
      tick_r <= wrap_s;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Self-checking bench for disp_scan_driver: two instances (normal and inverted pins)
// share the stimulus and are compared every cycle against a cycle-count based model.
module tb_disp_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int FRM = ND * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits = 16'h0000;
  logic [3:0]    dpv = 4'b0000;
  logic [3:0]    blink = 4'b0000;
  logic          hm = 1'b0;
  logic          blz = 1'b0;

  logic [6:0]    seg0, seg1;
  logic          dp0, dp1;
  logic [3:0]    an0, an1;
  logic          tick0, tick1;

  int            checks = 0;
  int            errors = 0;

  // model state
  int            n = 0;
  logic [15:0]   sd = 16'h0000;
  logic [3:0]    sdp = 4'b0000;
  logic [3:0]    sb = 4'b0000;
  logic [6:0]    e_seg;
  logic          e_dp;
  logic [3:0]    e_an;
  logic          e_tick;
  logic          chk_seg;

  logic [6:0] pat [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  disp_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .digits_in(digits), .dp_in(dpv), .blink_mask(blink),
    .hex_mode(hm), .blank_lz(blz), .seg(seg0), .dp(dp0), .an(an0), .frame_tick(tick0));

  disp_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .digits_in(digits), .dp_in(dpv), .blink_mask(blink),
    .hex_mode(hm), .blank_lz(blz), .seg(seg1), .dp(dp1), .an(an1), .frame_tick(tick1));

  always #5 clk = ~clk;

  // One clock: predict outputs from the elapsed cycle count and the snapshot, then compare.
  task automatic step();
    int c, i, f;
    logic [3:0] nib;
    logic lz, ph;
    @(posedge clk);
    if (rst) begin
      n = 0; sd = 16'h0000; sdp = 4'b0000; sb = 4'b0000;
      e_seg = 7'b0000000; e_dp = 1'b0; e_an = 4'b0000; e_tick = 1'b0; chk_seg = 1'b1;
    end else begin
      n = n + 1;
      c = (n - 1) % DIV;
      i = ((n - 1) / DIV) % ND;
      f = (n - 1) / FRM;
      nib = sd[4*i +: 4];
      lz = blz && (i > 0) && ((sd >> (4*i)) == 16'h0000);
      ph = ((f / BF) % 2) == 1;
      e_seg = (lz || (nib > 4'd9 && !hm)) ? 7'b0000000 : pat[nib];
      e_dp = sdp[i];
      if (ph && sb[i]) begin
        e_seg = 7'b0000000;
        e_dp = 1'b0;
      end
      e_an = (c == 0) ? 4'b0000 : (4'b0001 << i);
      e_tick = ((n % FRM) == 0);
      chk_seg = (c != 0);
      if (n == 1 || (n % FRM) == 0) begin
        sd = digits; sdp = dpv; sb = blink;
      end
    end
    #1;
    checks++;
    assert (an0 === e_an) else begin errors++; $error("FAIL an n=%0d obs=%b exp=%b", n, an0, e_an); end
    checks++;
    assert (an1 === ~e_an) else begin errors++; $error("FAIL an_al n=%0d obs=%b exp=%b", n, an1, ~e_an); end
    checks++;
    assert (tick0 === e_tick) else begin errors++; $error("FAIL tick n=%0d obs=%b exp=%b", n, tick0, e_tick); end
    checks++;
    assert (tick1 === e_tick) else begin errors++; $error("FAIL tick_al n=%0d obs=%b exp=%b", n, tick1, e_tick); end
    if (chk_seg) begin
      checks++;
      assert (seg0 === e_seg) else begin errors++; $error("FAIL seg n=%0d obs=%b exp=%b", n, seg0, e_seg); end
      checks++;
      assert (seg1 === ~e_seg) else begin errors++; $error("FAIL seg_al n=%0d obs=%b exp=%b", n, seg1, ~e_seg); end
      checks++;
      assert (dp0 === e_dp) else begin errors++; $error("FAIL dp n=%0d obs=%b exp=%b", n, dp0, e_dp); end
      checks++;
      assert (dp1 === ~e_dp) else begin errors++; $error("FAIL dp_al n=%0d obs=%b exp=%b", n, dp1, ~e_dp); end
    end
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    run(k);
    rst = 1'b0;
  endtask

  initial begin
    // reset held for 3 cycles
    do_reset(3);

    // plain decimal scan
    digits = 16'h1234; hm = 1'b0; blz = 1'b0; dpv = 4'b0000; blink = 4'b0000;
    run(2 * FRM);

    // hex decode on, then off
    digits = 16'hABCD; hm = 1'b1;
    run(2 * FRM);
    hm = 1'b0;
    run(2 * FRM);

    // leading-zero blanking
    blz = 1'b1; digits = 16'h0050;
    run(2 * FRM);
    digits = 16'h0000; dpv = 4'b0100;
    run(2 * FRM);
    dpv = 4'b0000; blz = 1'b0;

    // change input during the digit-1 slot: no tearing
    digits = 16'h1234;
    run(FRM);
    while ((n % FRM) != DIV + 2) step();
    digits = 16'h5678;
    run(2 * FRM);

    // mid-frame reset, then blink on digit 0 across 8 frames
    run(5);
    do_reset(2);
    blink = 4'b0001; digits = 16'h0789; dpv = 4'b0011;
    run(8 * FRM);

    // randomized inputs with occasional mid-run reset
    for (int k = 0; k < 40 * FRM; k++) begin
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dpv = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blink = 4'($urandom);
      if ($urandom_range(0, 19) == 0) hm = ~hm;
      if ($urandom_range(0, 19) == 0) blz = ~blz;
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
